// File: rtl/puf_ctrl_pkg.sv
// puf_ctrl_pkg: shared types, constants and helper functions for the RO-PUF measurement controller.
package puf_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, RACE, CAPTURE, NEXT, RESP} state_t;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_ZERO_SEED = 8'h01;
  typedef logic [15:0] ro_bank_t;
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction
  function automatic logic [31:0] ro_pair(input logic [7:0] s);
    ro_bank_t a, b;
    a = ro_bank_t'(1) << s[3:0];
    b = ro_bank_t'(1) << s[7:4];
    return {b, a};
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer with asynchronous active-high reset.
//   clock, reset : clock and async reset
//   d            : asynchronous input
//   q            : synchronized output
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clock or posedge reset)
    if (reset) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/puf_measure_ctrl.sv
// puf_measure_ctrl: sequencer that turns an 8-bit challenge into an N_BITS RO-PUF response.
//   req_*        : challenge handshake (accepted only in IDLE)
//   rsp_*        : response word, error flag and handshake
//   ro_enable    : RO enables, [15:0] bank A, [31:16] bank B
//   sel_a, sel_b : mux selects taken from the LFSR nibbles
//   cnt_clear, arb_clear : datapath clears
//   race_done, race_winner : asynchronous arbiter result, synchronized internally
// Optional build macro PUF_MAJORITY_VOTE_EN: each bit is a majority of three races.
module puf_measure_ctrl
  import puf_ctrl_pkg::*;
#(
  parameter int N_BITS         = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_challenge,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N_BITS-1:0] rsp_data,
  output logic              rsp_error,
  output logic [31:0]       ro_enable,
  output logic [3:0]        sel_a,
  output logic [3:0]        sel_b,
  output logic              cnt_clear,
  output logic              arb_clear,
  input  logic              race_done,
  input  logic              race_winner
);
  localparam int IW = N_BITS > 1 ? $clog2(N_BITS) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state;
  logic [7:0] lfsr;
  logic [IW-1:0] bit_idx;
  logic [SW-1:0] settle;
  logic [TW-1:0] tmo;
  logic [1:0] trial, votes;
  logic done_s, win_s, res, fin, last, bit_val;
  sync_2ff u_sync_done (.clock(clock), .reset(reset), .d(race_done), .q(done_s));
  sync_2ff u_sync_win (.clock(clock), .reset(reset), .d(race_winner), .q(win_s));
  assign sel_a = lfsr[3:0];
  assign sel_b = lfsr[7:4];
  // A trial ends either on a captured winner or on a RACE timeout, which scores as 0.
  assign res = state == CAPTURE && win_s;
  assign fin = state == CAPTURE || (state == RACE && !done_s && tmo == TW'(TIMEOUT_CYCLES - 1));
`ifdef PUF_MAJORITY_VOTE_EN
  assign last = trial == 2'd2;
  assign bit_val = (votes + {1'b0, res}) >= 2'd2;
`else
  assign last = 1'b1;
  assign bit_val = res;
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_error <= 1'b0;
      ro_enable <= '0;
      cnt_clear <= 1'b1;
      arb_clear <= 1'b1;
      lfsr <= '0;
      bit_idx <= '0;
      settle <= '0;
      tmo <= '0;
      trial <= '0;
      votes <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          lfsr <= req_challenge == 8'h00 ? LFSR_ZERO_SEED : req_challenge;
          bit_idx <= '0;
          trial <= '0;
          votes <= '0;
          rsp_data <= '0;
          rsp_error <= 1'b0;
          req_ready <= 1'b0;
          state <= CLEAR;
        end
        // Hold the clears while a stale race_done from the previous trial drains.
        CLEAR: if (!done_s) begin
          cnt_clear <= 1'b0;
          arb_clear <= 1'b0;
          ro_enable <= ro_pair(lfsr);
          settle <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          settle <= settle + 1'b1;
          if (settle == SW'(SETTLE_CYCLES - 1)) begin
            tmo <= '0;
            state <= RACE;
          end
        end
        RACE: begin
          tmo <= tmo == TW'(TIMEOUT_CYCLES) ? tmo : tmo + 1'b1;
          if (done_s) state <= CAPTURE;
          if (fin) rsp_error <= 1'b1;
        end
        CAPTURE: ;
        NEXT: begin
          lfsr <= lfsr_step(lfsr);
          trial <= '0;
          votes <= '0;
          bit_idx <= bit_idx + 1'b1;
          ro_enable <= '0;
          cnt_clear <= 1'b1;
          arb_clear <= 1'b1;
          rsp_valid <= bit_idx == IW'(N_BITS - 1);
          state <= bit_idx == IW'(N_BITS - 1) ? RESP : CLEAR;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (fin) begin
        if (last) begin
          rsp_data[bit_idx] <= bit_val;
          state <= NEXT;
        end else begin
          trial <= trial + 1'b1;
          votes <= votes + {1'b0, res};
          ro_enable <= '0;
          cnt_clear <= 1'b1;
          arb_clear <= 1'b1;
          state <= CLEAR;
        end
      end
    end
  end
endmodule

// File: tb/tb_puf_measure_ctrl.sv
// tb_puf_measure_ctrl: randomized self-checking bench with an LFSR/arbiter reference model.
module tb_puf_measure_ctrl;
  localparam int NB = 8;
  localparam int SC = 4;
  localparam int TO = 16;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int TR = 3;
`else
  localparam int TR = 1;
`endif
  localparam int RW = 45 + NB;
  logic clock = 0, reset = 1, req_valid = 0, rsp_ready = 0, race_done = 0, race_winner = 0;
  logic [7:0] req_challenge = 0;
  logic req_ready, rsp_valid, rsp_error, cnt_clear, arb_clear;
  logic [NB-1:0] rsp_data;
  logic [31:0] ro_enable;
  logic [3:0] sel_a, sel_b;
  int vectors = 0, miscompares = 0;
  int arb_mode = 0, pat_idx = 0, race_cnt = 0, race_delay = 0, run_len = 0, bad_pair = 0, clr_falls = 0;
  bit armed = 0, prev_en = 0, prev_clr = 1;
  logic [7:0] sel_q[$];
  int run_q[$];
  bit win_q[$];

  always #5 clock = ~clock;

  puf_measure_ctrl #(.N_BITS(NB), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_challenge(req_challenge), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_error(rsp_error), .ro_enable(ro_enable), .sel_a(sel_a),
    .sel_b(sel_b), .cnt_clear(cnt_clear), .arb_clear(arb_clear), .race_done(race_done),
    .race_winner(race_winner)
  );

  // Monitor plus arbiter model; mode 0 never finishes, 1 winner=(sel_a>sel_b), 2 pattern 1,0,1, 3 random.
  initial forever begin
    @(negedge clock);
    if (ro_enable != 0) begin
      if (ro_enable !== ((32'd1 << sel_a) | (32'd1 << (16 + int'(sel_b))))) bad_pair++;
      if (!prev_en) begin
        sel_q.push_back({sel_b, sel_a});
        run_len = 0;
      end
      run_len++;
    end else if (prev_en) run_q.push_back(run_len);
    if (prev_clr && !cnt_clear) clr_falls++;
    prev_en = ro_enable != 0;
    prev_clr = cnt_clear;
    if (arb_clear || ro_enable == 0) begin
      race_done = 0;
      armed = 0;
    end else if (!armed) begin
      armed = 1;
      race_cnt = 0;
      race_delay = $urandom_range(1, 8);
      race_winner = arb_mode == 1 ? (sel_a > sel_b) : arb_mode == 2 ? (pat_idx % 3 != 1) : 1'($urandom_range(0, 1));
      win_q.push_back(race_winner);
      pat_idx++;
    end else begin
      race_cnt++;
      if (arb_mode != 0 && race_cnt >= race_delay) race_done = 1;
    end
  end

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  function automatic logic [7:0] sel_at(input logic [7:0] c, input int k);
    logic [7:0] s;
    s = c == 0 ? 8'h01 : c;
    for (int i = 0; i < k; i++) s = lfsr_next(s);
    return s;
  endfunction

  function automatic logic [NB-1:0] exp_cmp(input logic [7:0] c);
    logic [NB-1:0] r;
    logic [7:0] s;
    for (int k = 0; k < NB; k++) begin
      s = sel_at(c, k);
      r[k] = s[3:0] > s[7:4];
    end
    return r;
  endfunction

  function automatic logic [NB-1:0] exp_vote();
    logic [NB-1:0] r;
    int n;
    for (int k = 0; k < NB; k++) begin
      n = 0;
      for (int t = 0; t < TR; t++) if (k * TR + t < win_q.size()) n += int'(win_q[k * TR + t]);
      r[k] = 2 * n > TR;
    end
    return r;
  endfunction

  function automatic int sel_errs(input logic [7:0] c);
    int e;
    if (sel_q.size() != NB * TR) return 1000 + sel_q.size();
    e = 0;
    for (int i = 0; i < NB * TR; i++) if (sel_q[i] !== sel_at(c, i / TR)) e++;
    return e;
  endfunction

  task automatic run_txn(input logic [7:0] c, input int mode, output logic [NB-1:0] data, output logic err, output bit ok);
    arb_mode = mode;
    pat_idx = 0;
    win_q.delete();
    sel_q.delete();
    run_q.delete();
    clr_falls = 0;
    @(negedge clock);
    req_challenge = c;
    req_valid = 1;
    @(negedge clock);
    req_valid = 0;
    ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clock);
      ok = rsp_valid === 1'b1;
    end
    data = rsp_data;
    err = rsp_error;
  endtask

  task automatic take_rsp();
    @(negedge clock);
    rsp_ready = 1;
    @(negedge clock);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    logic [RW-1:0] exp_v, obs;
    bit idle_ok, seen;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 32'h0, {NB{1'b0}}};
    reset = 1;
    repeat (3) @(negedge clock);
    obs = {req_ready, rsp_valid, rsp_error, cnt_clear, arb_clear, sel_a, sel_b, ro_enable, rsp_data};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL reset_held: got %h expected %h", obs, exp_v); end
    reset = 0;
    @(negedge clock);
    obs = {req_ready, rsp_valid, rsp_error, cnt_clear, arb_clear, sel_a, sel_b, ro_enable, rsp_data};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL reset_released: got %h expected %h", obs, exp_v); end
    arb_mode = 0;
    req_challenge = 8'h3C;
    req_valid = 1;
    @(negedge clock);
    req_valid = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = ro_enable != 0;
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL reset_race_start: got ro_enable %h expected nonzero", ro_enable); end
    repeat (SC + 2) @(negedge clock);
    reset = 1;
    #1;
    obs = {req_ready, rsp_valid, rsp_error, cnt_clear, arb_clear, sel_a, sel_b, ro_enable, rsp_data};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL reset_in_race: got %h expected %h", obs, exp_v); end
    @(negedge clock);
    reset = 0;
    idle_ok = 1;
    repeat (5) begin
      @(negedge clock);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) idle_ok = 0;
    end
    vectors++;
    if (!idle_ok) begin miscompares++; $display("FAIL reset_idle_after: got rsp_valid %b req_ready %b expected 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_basic();
    logic [NB-1:0] d;
    logic e;
    bit ok;
    run_txn(8'hA5, 1, d, e, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL basic_timeout: got no rsp_valid expected rsp_valid"); end
    vectors++;
    if (d !== exp_cmp(8'hA5)) begin miscompares++; $display("FAIL basic_data: got %h expected %h", d, exp_cmp(8'hA5)); end
    vectors++;
    if (e !== 1'b0) begin miscompares++; $display("FAIL basic_error: got %b expected 0", e); end
    vectors++;
    if (sel_errs(8'hA5) != 0) begin miscompares++; $display("FAIL basic_sel_seq: got %0d errors expected 0", sel_errs(8'hA5)); end
    vectors++;
    if (bad_pair != 0) begin miscompares++; $display("FAIL basic_ro_pair: got %0d bad samples expected 0", bad_pair); end
    take_rsp();
  endtask

  task automatic test_zero_challenge();
    logic [NB-1:0] d;
    logic e;
    bit ok;
    run_txn(8'h00, 1, d, e, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL zero_timeout: got no rsp_valid expected rsp_valid"); end
    vectors++;
    if (sel_q.size() == 0 || sel_q[0] !== 8'h01) begin miscompares++; $display("FAIL zero_first_sel: got %h expected 01", sel_q.size() ? sel_q[0] : 8'hxx); end
    vectors++;
    if (d !== exp_cmp(8'h00)) begin miscompares++; $display("FAIL zero_data: got %h expected %h", d, exp_cmp(8'h00)); end
    take_rsp();
  endtask

  task automatic test_timeout();
    logic [NB-1:0] d;
    logic e;
    bit ok;
    int bad;
    logic [7:0] c;
    c = 8'($urandom);
    run_txn(c, 0, d, e, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL tmo_wait: got no rsp_valid expected rsp_valid"); end
    vectors++;
    if (d !== '0) begin miscompares++; $display("FAIL tmo_data: got %h expected 0", d); end
    vectors++;
    if (e !== 1'b1) begin miscompares++; $display("FAIL tmo_error: got %b expected 1", e); end
    bad = run_q.size() == NB * TR ? 0 : 1000 + run_q.size();
    for (int i = 0; i < run_q.size() && i < NB * TR; i++)
      if (run_q[i] != SC + TO + (i % TR == TR - 1 ? 1 : 0)) bad++;
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL tmo_race_len: got %0d bad runs expected 0", bad); end
    take_rsp();
  endtask

  task automatic test_back_to_back();
    logic [NB-1:0] d;
    logic e;
    bit ok, stable, idle_ok;
    logic [7:0] c;
    c = 8'($urandom);
    run_txn(c, 1, d, e, ok);
    vectors++;
    if (!ok || d !== exp_cmp(c)) begin miscompares++; $display("FAIL bp_data: got %h expected %h", d, exp_cmp(c)); end
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i == 2) begin req_valid = 1; req_challenge = ~c; end
      if (i == 6) req_valid = 0;
      if (rsp_data !== d || rsp_valid !== 1'b1 || req_ready !== 1'b0) stable = 0;
    end
    vectors++;
    if (!stable) begin miscompares++; $display("FAIL bp_hold: got data %h valid %b ready %b expected %h 1 0", rsp_data, rsp_valid, req_ready, d); end
    take_rsp();
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_handshake: got ready %b valid %b expected 1 0", req_ready, rsp_valid); end
    idle_ok = 1;
    repeat (4) begin
      @(negedge clock);
      if (ro_enable !== 0 || req_ready !== 1'b1) idle_ok = 0;
    end
    vectors++;
    if (!idle_ok) begin miscompares++; $display("FAIL bp_ignored_req: got ro_enable %h ready %b expected 0 1", ro_enable, req_ready); end
  endtask

  task automatic test_random();
    logic [NB-1:0] d;
    logic e;
    bit ok;
    logic [7:0] c;
    for (int n = 0; n < 6; n++) begin
      c = 8'($urandom);
      run_txn(c, 3, d, e, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL rand_wait[%0d]: got no rsp_valid expected rsp_valid", n); end
      vectors++;
      if (d !== exp_vote()) begin miscompares++; $display("FAIL rand_data[%0d]: got %h expected %h", n, d, exp_vote()); end
      vectors++;
      if (e !== 1'b0) begin miscompares++; $display("FAIL rand_error[%0d]: got %b expected 0", n, e); end
      vectors++;
      if (sel_errs(c) != 0) begin miscompares++; $display("FAIL rand_sel_seq[%0d]: got %0d errors expected 0", n, sel_errs(c)); end
      take_rsp();
    end
  endtask

  task automatic test_majority();
    logic [NB-1:0] d;
    logic e;
    bit ok;
    run_txn(8'h5A, 2, d, e, ok);
    vectors++;
    if (!ok || d !== exp_vote()) begin miscompares++; $display("FAIL vote_data: got %h expected %h", d, exp_vote()); end
    vectors++;
    if (clr_falls != NB * TR) begin miscompares++; $display("FAIL vote_clear_pulses: got %0d expected %0d", clr_falls, NB * TR); end
`ifdef PUF_MAJORITY_VOTE_EN
    vectors++;
    if (d !== {NB{1'b1}}) begin miscompares++; $display("FAIL vote_all_ones: got %h expected all ones", d); end
`endif
    take_rsp();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_challenge();
    test_timeout();
    test_back_to_back();
    test_random();
    test_majority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
